// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus receiver: rs encoding and FIFO entry layout.
package lcd_pkg;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  // FIFO entry is packed as {rs, idx, data}
  function automatic int entry_w(input int idx_w);
    return 9 + idx_w;
  endfunction

endpackage

// File: rtl/lcd_rx_fifo.sv
// Synchronous FIFO with a fall-through head register; capacity DEPTH counts the head slot.
module lcd_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   mcnt, total;
  logic          hv;
  logic [W-1:0]  hd;
  logic          do_pop, do_push, slot_free, take, fall, to_mem;

  assign total     = mcnt + {{AW{1'b0}}, hv};
  assign full      = (total == (AW+1)'(DEPTH));
  assign empty     = ~hv;
  assign dout      = hd;
  assign do_pop    = pop & hv;
  assign do_push   = push & (~full | do_pop);
  assign slot_free = ~hv | do_pop;
  assign take      = slot_free & (mcnt != '0);
  // a push bypasses storage only when the head slot frees up and storage is empty
  assign fall      = do_push & slot_free & (mcnt == '0);
  assign to_mem    = do_push & ~fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv   <= 1'b0;
      hd   <= '0;
      wp   <= '0;
      rp   <= '0;
      mcnt <= '0;
    end else if (flush) begin
      hv   <= 1'b0;
      wp   <= '0;
      rp   <= '0;
      mcnt <= '0;
    end else begin
      if (take) begin
        hd <= mem[rp];
        rp <= rp + 1'b1;
        hv <= 1'b1;
      end else if (fall) begin
        hd <= din;
        hv <= 1'b1;
      end else if (do_pop) begin
        hv <= 1'b0;
      end
      if (to_mem) wp <= wp + 1'b1;
      mcnt <= mcnt + (AW+1)'(to_mem) - (AW+1)'(take);
    end
  end

  always_ff @(posedge clk) begin
    if (to_mem && !flush) mem[wp] <= din;
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// 8080-style LCD write-bus receiver: oversampled strobe detect, indexed byte FIFO, fmark generator.
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDX_W        = 16,
  parameter int FMARK_PERIOD = 1024,
  parameter int FMARK_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       lcd_d,
  input  logic             lcd_rs,
  input  logic             lcd_wr_n,
  input  logic             lcd_cs_n,
  input  logic             lcd_rst_n,
  output logic             lcd_fmark,
  output logic [7:0]       rx_data,
  output logic             rx_rs,
  output logic [IDX_W-1:0] rx_idx,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ovf,
  input  logic             ovf_clr,
  output logic             lcd_in_rst,
  input  logic             fmark_ena
);
  localparam int EW = entry_w(IDX_W);
  localparam int FW = (FMARK_PERIOD > 1) ? $clog2(FMARK_PERIOD) : 1;

  logic [3:1]      wr_s, cs_s, rst_s;
  logic [2:0][7:0] d_s;
  logic [2:0]      rs_s;
  logic            bus_rst, strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_s  <= 3'b111;
      cs_s  <= 3'b111;
      rst_s <= 3'b111;
      d_s   <= '0;
      rs_s  <= '0;
    end else begin
      wr_s  <= {wr_s[2:1], lcd_wr_n};
      cs_s  <= {cs_s[2:1], lcd_cs_n};
      rst_s <= {rst_s[2:1], lcd_rst_n};
      d_s   <= {d_s[1:0], lcd_d};
      rs_s  <= {rs_s[1:0], lcd_rs};
    end
  end

  assign bus_rst    = ~rst_s[2];
  assign lcd_in_rst = bus_rst;
  // rising wr_n seen between s3 and s2; d/rs at stage 3 are the last low-phase sample
  assign strobe     = ~wr_s[3] & wr_s[2] & ~cs_s[3] & ~bus_rst;

  logic             push_q;
  logic [EW-1:0]    ent_q;
  logic [IDX_W-1:0] idx_cnt, idx_nx;

  assign idx_nx = (&idx_cnt) ? idx_cnt : idx_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q  <= 1'b0;
      ent_q   <= '0;
      idx_cnt <= '0;
    end else if (bus_rst) begin
      push_q  <= 1'b0;
      idx_cnt <= '0;
    end else begin
      push_q <= strobe;
      if (strobe) begin
        if (rs_s[2] == LCD_RS_CMD) begin
          idx_cnt <= '0;
          ent_q   <= {LCD_RS_CMD, {IDX_W{1'b0}}, d_s[2]};
        end else begin
          idx_cnt <= idx_nx;
          ent_q   <= {LCD_RS_DATA, idx_nx, d_s[2]};
        end
      end
    end
  end

  logic [EW-1:0] head;
  logic          full, empty, pop, ovf;

  assign pop      = rx_valid & rx_ready;
  assign rx_valid = ~empty;
  assign ovf      = push_q & full & ~pop & ~bus_rst;

  lcd_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus_rst),
    .push  (push_q),
    .din   (ent_q),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign rx_data = head[7:0];
  assign rx_idx  = head[8 +: IDX_W];
  assign rx_rs   = head[EW-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rx_ovf <= 1'b0;
    else if (ovf)     rx_ovf <= 1'b1;
    else if (ovf_clr) rx_ovf <= 1'b0;
  end

  logic [FW-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt      <= '0;
      lcd_fmark <= 1'b0;
    end else if (!fmark_ena) begin
      fcnt      <= '0;
      lcd_fmark <= 1'b0;
    end else begin
      lcd_fmark <= (fcnt < FW'(FMARK_WIDTH));
      fcnt      <= (fcnt == FW'(FMARK_PERIOD - 1)) ? '0 : fcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Directed bench for lcd_bus_rx with a queue-based model of the expected receive stream.
module tb_lcd_bus_rx;
  localparam int DEPTH = 4;
  localparam int IW    = 16;
  localparam int FP    = 20;
  localparam int FWID  = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [7:0]    lcd_d = '0;
  logic          lcd_rs = 1'b0, lcd_wr_n = 1'b1, lcd_cs_n = 1'b1, lcd_rst_n = 1'b1;
  logic          lcd_fmark, rx_rs, rx_valid, rx_ovf, lcd_in_rst;
  logic [7:0]    rx_data;
  logic [IW-1:0] rx_idx;
  logic          rx_ready = 1'b0, ovf_clr = 1'b0, fmark_ena = 1'b0;

  lcd_bus_rx #(.FIFO_DEPTH(DEPTH), .IDX_W(IW), .FMARK_PERIOD(FP), .FMARK_WIDTH(FWID)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_d(lcd_d), .lcd_rs(lcd_rs), .lcd_wr_n(lcd_wr_n),
    .lcd_cs_n(lcd_cs_n), .lcd_rst_n(lcd_rst_n), .lcd_fmark(lcd_fmark), .rx_data(rx_data),
    .rx_rs(rx_rs), .rx_idx(rx_idx), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_ovf(rx_ovf),
    .ovf_clr(ovf_clr), .lcd_in_rst(lcd_in_rst), .fmark_ena(fmark_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    d;
    logic          rs;
    logic [IW-1:0] idx;
  } ent_t;

  ent_t          q[$];
  ent_t          log_q[$];
  logic [IW-1:0] m_idx = '0;
  logic          m_ovf = 1'b0;
  logic          chk_en = 1'b0;
  int            n_cmp = 0, n_bad = 0;
  int            lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input ent_t e);
    return {7'd0, e.rs, e.idx, e.d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one bus write: wr_n low 3 clk, high 5 clk; model updated at the wr_n rise
  task automatic wr(input logic [7:0] d, input logic rs, input logic cs, input logic meas);
    ent_t e;
    lcd_d = d; lcd_rs = rs; lcd_cs_n = cs; lcd_wr_n = 1'b0;
    repeat (3) step();
    lcd_wr_n = 1'b1;
    if (!cs) begin
      if (rs) m_idx = (m_idx == {IW{1'b1}}) ? m_idx : m_idx + 1'b1;
      else    m_idx = '0;
      e.d = d; e.rs = rs; e.idx = rs ? m_idx : '0;
      if (q.size() < DEPTH) q.push_back(e);
      else                  m_ovf = 1'b1;
    end
    lat = -1;
    for (int n = 1; n <= 5; n++) begin
      step();
      if (rx_valid && lat < 0) lat = n;
    end
    if (meas) chk("latency", lat, 4);
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n && rx_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("head", {7'd0, rx_rs, rx_idx, rx_data}, pk(q[0]));
        if (rx_ready) log_q.push_back(q.pop_front());
      end
    end
  end

  initial begin
    repeat (5) step();
    chk("rst_valid", rx_valid, 0);
    chk("rst_ovf", rx_ovf, 0);
    chk("rst_fmark", lcd_fmark, 0);
    chk("rst_in_rst", lcd_in_rst, 0);
    chk("rst_head", {7'd0, rx_rs, rx_idx, rx_data}, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (20) step();
    chk("idle_valid", rx_valid, 0);

    // command then three data bytes
    rx_ready = 1'b1;
    log_q.delete();
    wr(8'h2C, 1'b0, 1'b0, 1'b1);
    wr(8'h11, 1'b1, 1'b0, 1'b1);
    wr(8'h22, 1'b1, 1'b0, 1'b1);
    wr(8'h33, 1'b1, 1'b0, 1'b1);
    chk("cmd_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("cmd_b0", pk(log_q[0]), {7'd0, 1'b0, 16'd0, 8'h2C});
      chk("cmd_b1", pk(log_q[1]), {7'd0, 1'b1, 16'd1, 8'h11});
      chk("cmd_b2", pk(log_q[2]), {7'd0, 1'b1, 16'd2, 8'h22});
      chk("cmd_b3", pk(log_q[3]), {7'd0, 1'b1, 16'd3, 8'h33});
    end
    chk("cmd_drained", q.size(), 0);

    // cs_n gating
    log_q.delete();
    wr(8'hAA, 1'b0, 1'b1, 1'b0);
    wr(8'h55, 1'b0, 1'b0, 1'b0);
    chk("cs_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("cs_byte", pk(log_q[0]), {7'd0, 1'b0, 16'd0, 8'h55});

    // overflow
    rx_ready = 1'b0;
    log_q.delete();
    for (int i = 1; i <= 6; i++) wr(8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_set", rx_ovf, 1);
    chk("ovf_model", rx_ovf, m_ovf);
    chk("ovf_qlen", q.size(), 4);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0; step();
    m_ovf = 1'b0;
    chk("ovf_clr", rx_ovf, 0);
    rx_ready = 1'b1;
    repeat (8) step();
    chk("drain_count", log_q.size(), 4);
    if (log_q.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("drain_byte", pk(log_q[i]), {7'd0, 1'b1, 16'(i + 1), 8'(i + 1)});
    wr(8'h07, 1'b1, 1'b0, 1'b0);
    chk("post_ovf_count", log_q.size(), 5);
    if (log_q.size() == 5) chk("post_ovf_byte", pk(log_q[4]), {7'd0, 1'b1, 16'd7, 8'h07});

    // bus reset flushes the queue and the index counter
    rx_ready = 1'b0;
    wr(8'hA1, 1'b1, 1'b0, 1'b0);
    wr(8'hA2, 1'b1, 1'b0, 1'b0);
    chk("brst_pre_valid", rx_valid, 1);
    chk_en = 1'b0;
    lcd_rst_n = 1'b0;
    q.delete();
    m_idx = '0;
    repeat (4) step();
    chk("brst_in_rst", lcd_in_rst, 1);
    chk("brst_valid", rx_valid, 0);
    chk("brst_ovf", rx_ovf, 0);
    lcd_rst_n = 1'b1;
    repeat (4) step();
    chk("brst_release", lcd_in_rst, 0);
    chk("brst_still_empty", rx_valid, 0);
    chk_en = 1'b1;
    rx_ready = 1'b1;
    log_q.delete();
    wr(8'h9E, 1'b1, 1'b0, 1'b0);
    chk("brst_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("brst_byte", pk(log_q[0]), {7'd0, 1'b1, 16'd1, 8'h9E});

    // fmark
    fmark_ena = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      chk("fmark", lcd_fmark, (((k - 1) % FP) < FWID) ? 1 : 0);
    end
    step();
    chk("fmark_mid", lcd_fmark, 1);
    fmark_ena = 1'b0;
    step();
    chk("fmark_off", lcd_fmark, 0);
    repeat (3) step();
    chk("fmark_held", lcd_fmark, 0);

    // async reset right as a strobe completes: the byte must be discarded
    rx_ready = 1'b0;
    lcd_d = 8'hC3; lcd_rs = 1'b1; lcd_cs_n = 1'b0; lcd_wr_n = 1'b0;
    repeat (3) step();
    chk_en = 1'b0;
    lcd_wr_n = 1'b1;
    rst_n = 1'b0;
    m_idx = '0;
    repeat (2) step();
    chk("arst_valid", rx_valid, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (10) step();
    chk("arst_discard", rx_valid, 0);
    chk("final_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
